// File: rtl/rom_stream_loader_if.sv
// Stream + memory bus bundle for rom_stream_loader.
//   s_valid / s_data / s_ready : word source handshake into the loader
//   mem_we / mem_re / mem_addr : registered memory strobes and address from the loader
//   mem_wdata / mem_rdata      : memory write data out, read data back in (1 cycle after mem_re)
// slave  : the loader's view (consumes the stream, drives the memory)
// master : the environment's view (word source + memory)
interface rom_stream_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  mem_we;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  s_valid, s_data, mem_rdata,
        output s_ready, mem_we, mem_re, mem_addr, mem_wdata
    );

    modport master (
        output s_valid, s_data, mem_rdata,
        input  s_ready, mem_we, mem_re, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rom_stream_loader.sv
// Loads NUM_WORDS stream words into a synchronous single-port memory at
// ascending addresses, then optionally takes a second (golden) pass, reads
// the memory back and counts mismatches.
//   i_clock0          clock, rising edge
//   i_global_resetn   asynchronous active-low reset
//   i_start           1-cycle run request, ignored while busy
//   i_verify_en       sampled with i_start; 1 = run the readback pass
//   bus               stream handshake + memory port (slave modport)
//   o_busy            high while a run is in progress
//   o_done            set at completion, cleared by the next accepted start
//   o_err_count       readback mismatch count, saturating
//   o_first_err_addr  address of the first mismatch of the run (0 if none)
//
// state    | meaning
// S_IDLE   | waiting for i_start, s_ready low
// S_WRITE  | accepting words, one memory write per handshake
// S_VERIFY | accepting golden words, one memory read per handshake
// S_DRAIN  | s_ready low, waiting for the last readback compare
module rom_stream_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int NUM_WORDS  = 128
) (
    input  logic                  i_clock0,
    input  logic                  i_global_resetn,
    input  logic                  i_start,
    input  logic                  i_verify_en,
    rom_stream_loader_if.slave    bus,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH:0]   o_err_count,
    output logic [ADDR_WIDTH-1:0] o_first_err_addr
);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH:0]   ERR_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_VERIFY,
        S_DRAIN
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_count;
    logic                  r_verify;
    logic                  r_mem_we;
    logic                  r_mem_re;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_exp_d1;
    logic [DATA_WIDTH-1:0] r_exp_d2;
    logic                  r_cmp_v;
    logic [ADDR_WIDTH-1:0] r_cmp_addr;
    logic                  r_done;
    logic [ADDR_WIDTH:0]   r_err_count;
    logic [ADDR_WIDTH-1:0] r_first_err_addr;

    logic                  w_s_ready;
    logic                  w_wr_hs;
    logic                  w_rd_hs;
    logic                  w_last;
    logic                  w_start_run;
    logic                  w_finish;
    logic                  w_mismatch;

    assign w_last     = (r_count == LAST_IDX);
    // Read data for the word read one cycle earlier is on mem_rdata while
    // r_cmp_v is high; its golden word has travelled the two-stage r_exp pipe.
    assign w_mismatch = r_cmp_v && (bus.mem_rdata != r_exp_d2);

    always_ff @(posedge i_clock0 or negedge i_global_resetn) begin
        if (!i_global_resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_ready   = 1'b0;
        w_wr_hs     = 1'b0;
        w_rd_hs     = 1'b0;
        w_start_run = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_start_run = 1'b1;
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_s_ready = 1'b1;
                if (bus.s_valid) begin
                    w_wr_hs = 1'b1;
                    if (w_last) begin
                        if (r_verify) begin
                            w_state_nxt = S_VERIFY;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_finish    = 1'b1;
                        end
                    end
                end
            end
            S_VERIFY: begin
                w_s_ready = 1'b1;
                if (bus.s_valid) begin
                    w_rd_hs = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Once the final read strobe has retired, its compare is
                // the one being registered on this edge.
                if (!r_mem_re) begin
                    w_state_nxt = S_IDLE;
                    w_finish    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock0 or negedge i_global_resetn) begin
        if (!i_global_resetn) begin
            r_count          <= '0;
            r_verify         <= 1'b0;
            r_mem_we         <= 1'b0;
            r_mem_re         <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_wdata      <= '0;
            r_exp_d1         <= '0;
            r_exp_d2         <= '0;
            r_cmp_v          <= 1'b0;
            r_cmp_addr       <= '0;
            r_done           <= 1'b0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
        end else begin
            r_mem_we   <= w_wr_hs;
            r_mem_re   <= w_rd_hs;
            r_cmp_v    <= r_mem_re;
            r_cmp_addr <= r_mem_addr;
            r_exp_d2   <= r_exp_d1;

            if (w_wr_hs || w_rd_hs) begin
                r_mem_addr <= r_count;
            end
            if (w_wr_hs) begin
                r_mem_wdata <= bus.s_data;
            end
            if (w_rd_hs) begin
                r_exp_d1 <= bus.s_data;
            end

            // The last word of a pass reloads 0 so the verify pass restarts
            // at address 0 and the counter never wraps.
            if (w_start_run) begin
                r_count  <= '0;
                r_verify <= i_verify_en;
            end else if (w_wr_hs || w_rd_hs) begin
                r_count <= w_last ? '0 : r_count + 1'b1;
            end

            if (w_start_run) begin
                r_done <= 1'b0;
            end else if (w_finish) begin
                r_done <= 1'b1;
            end

            if (w_start_run) begin
                r_err_count      <= '0;
                r_first_err_addr <= '0;
            end else if (w_mismatch) begin
                if (r_err_count != ERR_MAX) begin
                    r_err_count <= r_err_count + 1'b1;
                end
                if (r_err_count == '0) begin
                    r_first_err_addr <= r_cmp_addr;
                end
            end
        end
    end

    assign bus.s_ready      = w_s_ready;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_re       = r_mem_re;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign o_busy           = (r_state != S_IDLE);
    assign o_done           = r_done;
    assign o_err_count      = r_err_count;
    assign o_first_err_addr = r_first_err_addr;
endmodule
